processor_onchip_memory_arbiter: RTL and testbench
==================================================

Name: processor_onchip_memory_arbiter

Overview:
Two-master arbiter placed directly upstream of the single-port 1024x32 on-chip RAM slave. It merges a read-only instruction-fetch port (A) and a read/write data port (B) onto one Avalon-MM slave interface. It grants one access per cycle, applies waitrequest back-pressure to the losing master, and routes read data back with fixed 1-cycle latency and readdatavalid. The RAM latches the address on the clock edge and has an unregistered q, so data for a read issued in cycle N is valid during cycle N+1.

Parameters:
ADDR_W, 10, word-address width (1024 words)
DATA_W, 32, data width
BE_W, 4, byteenable width (DATA_W/8)
FIXED_PRIO_B, 0, 0 = round-robin; 1 = port B always wins ties

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
a_address  in  ADDR_W  port A word address
a_read  in  1  port A read request
a_waitrequest  out  1  port A stall
a_readdata  out  DATA_W  port A read data
a_readdatavalid  out  1  port A data valid
b_address  in  ADDR_W  port B word address
b_read  in  1  port B read request
b_write  in  1  port B write request
b_byteenable  in  BE_W  port B byte lanes
b_writedata  in  DATA_W  port B write data
b_waitrequest  out  1  port B stall
b_readdata  out  DATA_W  port B read data
b_readdatavalid  out  1  port B data valid
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  BE_W  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken, constant 1
mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Reset is asynchronous, active-high. It clears last_grant to B, so A wins the first tie. It clears the rd_pend_a/rd_pend_b flags. While reset is high: both waitrequests = 1, both readdatavalids = 0, mem_chipselect = 0, mem_write = 0.
- Request definitions: req_a = a_read; req_b = b_read | b_write.
- Grant is combinational, and at most one grant per cycle:
  - Only one requester: that requester is granted.
  - Both requesting with FIXED_PRIO_B = 1: B is granted.
  - Both requesting otherwise: the port not recorded in last_grant is granted.
- last_grant updates on every granted cycle. It holds its value when idle.
- x_waitrequest = req_x & ~grant_x. It is 0 when the port is not requesting.
- Masters hold address, data and controls stable while waitrequest = 1. The arbiter does not latch requests.
- RAM drive:
  - mem_chipselect = grant_a | grant_b.
  - mem_address, mem_byteenable and mem_writedata come from the granted port. Port A byteenable is forced to 4'hF.
  - mem_write = grant_b & b_write.
  - With no grant, the address and data outputs follow port B and are don't-care.
- b_read & b_write both high is illegal. The write takes effect and no readdatavalid is produced.
- Read return:
  - A granted read sets rd_pend_x at the clock edge. rd_pend_x is cleared at the next edge unless re-granted.
  - x_readdatavalid = rd_pend_x.
  - a_readdata = b_readdata = mem_readdata (broadcast). Read data is meaningful only when qualified by valid.
- Throughput and latency: one access per cycle, back-to-back reads with full throughput, read latency exactly 1 cycle, write latency 0 (the write completes at the grant edge).
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset asserted mid-operation drops in-flight reads. No readdatavalid appears after reset is released.

Decomposition:
- Package processor_mem_pkg contains:
  - constants MEM_ADDR_W = 10, MEM_DATA_W = 32, MEM_BE_W = 4;
  - enum port_id_t {PORT_A, PORT_B}, used for last_grant.
- One sub-module, processor_rr_arbiter2: a 2-way round-robin/fixed-priority grant with a last_grant register.
- The top level holds the datapath mux and the read-pending flags.

Test Plan:
- Reset release with no requests -> waitrequests = 0, readdatavalids = 0, mem_chipselect = 0 held for 10 cycles.
- A reads address 0x005 alone, RAM word = 0x1234_5678 -> granted in cycle N; a_readdatavalid = 1 in N+1 with 0x1234_5678; 4 back-to-back reads give 4 consecutive valid cycles.
- B writes 0xDEAD_BEEF to 0x3FF with byteenable 4'b0011, then reads 0x3FF -> read returns {old[31:16], 16'hBEEF}, 1 cycle after the read grant.
- A and B request continuously, round-robin mode -> grants alternate A, B, A, B; each waitrequest is high on alternate cycles; no starvation over 100 cycles.
- FIXED_PRIO_B = 1, both requesting for 3 cycles -> B granted for all 3; a_waitrequest = 1 throughout; A is granted in cycle 4 once B drops.
- A read granted, then reset pulsed in the next cycle -> a_readdatavalid = 0 during and after reset; the first post-reset tie is granted to A.

Source files
------------

// File: rtl/processor_mem_pkg.sv
// Shared constants and the port identifier for the on-chip RAM arbiter.
package processor_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = 4;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

endpackage

// File: rtl/processor_rr_arbiter2.sv
// Two-way grant: round-robin on ties, or B-always-wins when FIXED_PRIO_B is set.
module processor_rr_arbiter2
    import processor_mem_pkg::*;
#(
    parameter bit FIXED_PRIO_B = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic grant_a_o,
    output logic grant_b_o
);

    port_id_t last_grant_q;
    port_id_t last_grant_d;

    // Remember the most recent winner; reset leaves B recorded so A takes the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= PORT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Pick at most one winner this cycle and compute the next last_grant.
    always_comb begin
        grant_a_o    = 1'b0;
        grant_b_o    = 1'b0;
        last_grant_d = last_grant_q;
        if (req_a_i && req_b_i) begin
            if (FIXED_PRIO_B || (last_grant_q == PORT_A)) begin
                grant_b_o = 1'b1;
            end else begin
                grant_a_o = 1'b1;
            end
        end else begin
            grant_a_o = req_a_i;
            grant_b_o = req_b_i;
        end
        if (grant_a_o) begin
            last_grant_d = PORT_A;
        end else if (grant_b_o) begin
            last_grant_d = PORT_B;
        end
    end

endmodule

// File: rtl/processor_onchip_memory_arbiter.sv
// Merges instruction-fetch port A and data port B onto the single-port on-chip RAM.
module processor_onchip_memory_arbiter
    import processor_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = MEM_ADDR_W,
    parameter int unsigned DATA_W       = MEM_DATA_W,
    parameter int unsigned BE_W         = MEM_BE_W,
    parameter bit          FIXED_PRIO_B = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_read,
    output logic              a_waitrequest,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic [DATA_W-1:0] b_writedata,
    output logic              b_waitrequest,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic req_a;
    logic req_b;
    logic grant_a;
    logic grant_b;
    logic rd_pend_a_q;
    logic rd_pend_a_d;
    logic rd_pend_b_q;
    logic rd_pend_b_d;

    // Requests are masked during reset so nothing reaches the RAM or the arbiter.
    assign req_a = a_read & ~reset;
    assign req_b = (b_read | b_write) & ~reset;

    processor_rr_arbiter2 #(
        .FIXED_PRIO_B (FIXED_PRIO_B)
    ) u_arb (
        .clk_i     (clk),
        .rst_i     (reset),
        .req_a_i   (req_a),
        .req_b_i   (req_b),
        .grant_a_o (grant_a),
        .grant_b_o (grant_b)
    );

    // Route the granted port onto the RAM; with no grant the B side is passed through.
    always_comb begin
        mem_chipselect = grant_a | grant_b;
        mem_write      = grant_b & b_write;
        mem_clken      = 1'b1;
        mem_address    = b_address;
        mem_byteenable = b_byteenable;
        mem_writedata  = b_writedata;
        if (grant_a) begin
            mem_address    = a_address;
            mem_byteenable = '1;
        end
    end

    // Stall only a requesting loser; both stalls are forced high during reset.
    always_comb begin
        a_waitrequest = reset | (a_read & ~grant_a);
        b_waitrequest = reset | ((b_read | b_write) & ~grant_b);
    end

    // A granted read returns one cycle later; a simultaneous B write suppresses the B read.
    always_comb begin
        rd_pend_a_d = grant_a & a_read;
        rd_pend_b_d = grant_b & b_read & ~b_write;
    end

    // Read-pending flags; reset drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_a_q <= 1'b0;
            rd_pend_b_q <= 1'b0;
        end else begin
            rd_pend_a_q <= rd_pend_a_d;
            rd_pend_b_q <= rd_pend_b_d;
        end
    end

    // Read data is broadcast; valid qualifies it per port.
    always_comb begin
        a_readdatavalid = rd_pend_a_q & ~reset;
        b_readdatavalid = rd_pend_b_q & ~reset;
        a_readdata      = mem_readdata;
        b_readdata      = mem_readdata;
    end

endmodule

// File: tb/tb_processor_onchip_memory_arbiter.sv
// Self-checking bench: behavioural RAM, shadow-memory scoreboard, per-scenario tasks.
module tb_processor_onchip_memory_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [9:0]  a_address;
    logic        a_read;
    logic        a_waitrequest;
    logic [31:0] a_readdata;
    logic        a_readdatavalid;
    logic [9:0]  b_address;
    logic        b_read;
    logic        b_write;
    logic [3:0]  b_byteenable;
    logic [31:0] b_writedata;
    logic        b_waitrequest;
    logic [31:0] b_readdata;
    logic        b_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    // Second instance, fixed priority to B, with its own stimulus.
    logic [9:0]  f_a_address;
    logic        f_a_read;
    logic        f_a_waitrequest;
    logic [31:0] f_a_readdata;
    logic        f_a_readdatavalid;
    logic [9:0]  f_b_address;
    logic        f_b_read;
    logic        f_b_write;
    logic [3:0]  f_b_byteenable;
    logic [31:0] f_b_writedata;
    logic        f_b_waitrequest;
    logic [31:0] f_b_readdata;
    logic        f_b_readdatavalid;
    logic [9:0]  f_mem_address;
    logic [3:0]  f_mem_byteenable;
    logic        f_mem_chipselect;
    logic        f_mem_write;
    logic [31:0] f_mem_writedata;
    logic        f_mem_clken;
    logic [31:0] f_mem_readdata;

    processor_onchip_memory_arbiter #(
        .ADDR_W(10), .DATA_W(32), .BE_W(4), .FIXED_PRIO_B(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .a_address(a_address), .a_read(a_read), .a_waitrequest(a_waitrequest),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_read(b_read), .b_write(b_write),
        .b_byteenable(b_byteenable), .b_writedata(b_writedata),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
        .b_readdatavalid(b_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    processor_onchip_memory_arbiter #(
        .ADDR_W(10), .DATA_W(32), .BE_W(4), .FIXED_PRIO_B(1'b1)
    ) dut_fix (
        .clk(clk), .reset(reset),
        .a_address(f_a_address), .a_read(f_a_read), .a_waitrequest(f_a_waitrequest),
        .a_readdata(f_a_readdata), .a_readdatavalid(f_a_readdatavalid),
        .b_address(f_b_address), .b_read(f_b_read), .b_write(f_b_write),
        .b_byteenable(f_b_byteenable), .b_writedata(f_b_writedata),
        .b_waitrequest(f_b_waitrequest), .b_readdata(f_b_readdata),
        .b_readdatavalid(f_b_readdatavalid),
        .mem_address(f_mem_address), .mem_byteenable(f_mem_byteenable),
        .mem_chipselect(f_mem_chipselect), .mem_write(f_mem_write),
        .mem_writedata(f_mem_writedata), .mem_clken(f_mem_clken),
        .mem_readdata(f_mem_readdata)
    );

    // Behavioural single-port RAM: address registered on the edge, q unregistered.
    logic [31:0] ram    [1024];
    logic [31:0] shadow [1024];
    logic [9:0]  ram_addr_q = '0;
    assign mem_readdata = ram[ram_addr_q];

    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int i = 0; i < 4; i++)
                    if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
            end
            ram_addr_q <= mem_address;
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    // Scoreboard monitor: each expected read must appear exactly on its due cycle.
    always @(negedge clk) begin
        if (qa.size() > 0 && qa[0].due == cyc) begin
            nchk++;
            if (a_readdatavalid !== 1'b1 || a_readdata !== qa[0].data) begin
                nerr++;
                $display("FAIL a_read_return: valid=%b data=%h expected valid=1 data=%h", a_readdatavalid, a_readdata, qa[0].data);
            end
            void'(qa.pop_front());
        end else if (a_readdatavalid !== 1'b0) begin
            nchk++; nerr++;
            $display("FAIL a_unexpected_valid: valid=%b expected 0 (cycle %0d)", a_readdatavalid, cyc);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            nchk++;
            if (b_readdatavalid !== 1'b1 || b_readdata !== qb[0].data) begin
                nerr++;
                $display("FAIL b_read_return: valid=%b data=%h expected valid=1 data=%h", b_readdatavalid, b_readdata, qb[0].data);
            end
            void'(qb.pop_front());
        end else if (b_readdatavalid !== 1'b0) begin
            nchk++; nerr++;
            $display("FAIL b_unexpected_valid: valid=%b expected 0 (cycle %0d)", b_readdatavalid, cyc);
        end
    end

    task automatic idle_inputs();
        a_read = 1'b0; b_read = 1'b0; b_write = 1'b0;
        f_a_read = 1'b0; f_b_read = 1'b0; f_b_write = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_read = 1'b1; b_write = 1'b1; b_read = 1'b0;
        @(negedge clk);
        nchk++; if (a_waitrequest !== 1'b1) begin nerr++; $display("FAIL rst_a_wait: got %b expected 1", a_waitrequest); end
        nchk++; if (b_waitrequest !== 1'b1) begin nerr++; $display("FAIL rst_b_wait: got %b expected 1", b_waitrequest); end
        nchk++; if (mem_chipselect !== 1'b0) begin nerr++; $display("FAIL rst_cs: got %b expected 0", mem_chipselect); end
        nchk++; if (mem_write !== 1'b0) begin nerr++; $display("FAIL rst_write: got %b expected 0", mem_write); end
        nchk++; if (mem_clken !== 1'b1) begin nerr++; $display("FAIL rst_clken: got %b expected 1", mem_clken); end
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            nchk++; if (a_waitrequest !== 1'b0 || b_waitrequest !== 1'b0) begin nerr++; $display("FAIL idle_wait: got a=%b b=%b expected 0 0", a_waitrequest, b_waitrequest); end
            nchk++; if (mem_chipselect !== 1'b0) begin nerr++; $display("FAIL idle_cs: got %b expected 0", mem_chipselect); end
            next_cycle();
        end
    endtask

    task automatic test_a_read();
        a_address = 10'h005; a_read = 1'b1;
        @(negedge clk);
        nchk++; if (a_waitrequest !== 1'b0 || mem_chipselect !== 1'b1) begin nerr++; $display("FAIL a_grant: wait=%b cs=%b expected 0 1", a_waitrequest, mem_chipselect); end
        nchk++; if (mem_address !== 10'h005 || mem_byteenable !== 4'hF || mem_write !== 1'b0) begin nerr++; $display("FAIL a_drive: addr=%h be=%h wr=%b expected 005 f 0", mem_address, mem_byteenable, mem_write); end
        qa.push_back('{cyc + 1, 32'h1234_5678});
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            a_address = 10'(5 + k); a_read = 1'b1;
            @(negedge clk);
            nchk++; if (a_waitrequest !== 1'b0) begin nerr++; $display("FAIL a_b2b_wait[%0d]: got %b expected 0", k, a_waitrequest); end
            qa.push_back('{cyc + 1, shadow[5 + k]});
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_b_write_read();
        logic [31:0] old;
        logic [31:0] merged;
        old = shadow[10'h3FF];
        merged = {old[31:16], 16'hBEEF};
        b_address = 10'h3FF; b_write = 1'b1; b_byteenable = 4'b0011; b_writedata = 32'hDEAD_BEEF;
        @(negedge clk);
        nchk++; if (b_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_chipselect !== 1'b1) begin nerr++; $display("FAIL b_write_ctl: wait=%b wr=%b cs=%b expected 0 1 1", b_waitrequest, mem_write, mem_chipselect); end
        nchk++; if (mem_address !== 10'h3FF || mem_byteenable !== 4'b0011 || mem_writedata !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL b_write_drive: addr=%h be=%h wd=%h expected 3ff 3 deadbeef", mem_address, mem_byteenable, mem_writedata); end
        shadow[10'h3FF] = merged;
        next_cycle();
        b_write = 1'b0; b_read = 1'b1;
        @(negedge clk);
        nchk++; if (b_waitrequest !== 1'b0 || mem_write !== 1'b0) begin nerr++; $display("FAIL b_read_ctl: wait=%b wr=%b expected 0 0", b_waitrequest, mem_write); end
        qb.push_back('{cyc + 1, merged});
        next_cycle();
        // read and write together: write lands, no read data comes back
        b_address = 10'h020; b_read = 1'b1; b_write = 1'b1; b_byteenable = 4'hF; b_writedata = 32'h0BAD_F00D;
        @(negedge clk);
        nchk++; if (mem_write !== 1'b1 || mem_writedata !== 32'h0BAD_F00D) begin nerr++; $display("FAIL b_illegal_write: wr=%b wd=%h expected 1 0badf00d", mem_write, mem_writedata); end
        shadow[10'h020] = 32'h0BAD_F00D;
        next_cycle();
        b_write = 1'b0; b_read = 1'b1;
        @(negedge clk);
        qb.push_back('{cyc + 1, 32'h0BAD_F00D});
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [9:0] aa;
        logic [9:0] ba;
        bit a_turn;
        b_address = 10'h100; b_read = 1'b1;
        @(negedge clk);
        nchk++; if (b_waitrequest !== 1'b0) begin nerr++; $display("FAIL rr_prime: got %b expected 0", b_waitrequest); end
        qb.push_back('{cyc + 1, shadow[10'h100]});
        next_cycle();
        aa = 10'h010; ba = 10'h101; a_turn = 1'b1;
        repeat (100) begin
            a_read = 1'b1; b_read = 1'b1; a_address = aa; b_address = ba;
            @(negedge clk);
            nchk++;
            if (a_waitrequest !== !a_turn || b_waitrequest !== a_turn || mem_address !== (a_turn ? aa : ba)) begin
                nerr++;
                $display("FAIL rr_grant: wait a=%b b=%b addr=%h expected a=%b b=%b addr=%h", a_waitrequest, b_waitrequest, mem_address, !a_turn, a_turn, a_turn ? aa : ba);
            end
            if (a_turn) begin qa.push_back('{cyc + 1, shadow[aa]}); aa = aa + 10'd1; end
            else        begin qb.push_back('{cyc + 1, shadow[ba]}); ba = ba + 10'd1; end
            a_turn = !a_turn;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_fixed_prio();
        f_a_address = 10'h011; f_b_address = 10'h022; f_a_read = 1'b1; f_b_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nchk++; if (f_a_waitrequest !== 1'b1 || f_b_waitrequest !== 1'b0) begin nerr++; $display("FAIL fix_tie[%0d]: wait a=%b b=%b expected 1 0", k, f_a_waitrequest, f_b_waitrequest); end
            nchk++; if (f_mem_address !== 10'h022) begin nerr++; $display("FAIL fix_addr[%0d]: got %h expected 022", k, f_mem_address); end
            next_cycle();
        end
        f_b_read = 1'b0;
        @(negedge clk);
        nchk++; if (f_a_waitrequest !== 1'b0 || f_mem_address !== 10'h011 || f_b_readdatavalid !== 1'b1) begin nerr++; $display("FAIL fix_a_after: wait=%b addr=%h bvalid=%b expected 0 011 1", f_a_waitrequest, f_mem_address, f_b_readdatavalid); end
        next_cycle();
        f_a_read = 1'b0;
        @(negedge clk);
        nchk++; if (f_a_readdatavalid !== 1'b1 || f_b_readdatavalid !== 1'b0) begin nerr++; $display("FAIL fix_valids: a=%b b=%b expected 1 0", f_a_readdatavalid, f_b_readdatavalid); end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        a_address = 10'h007; a_read = 1'b1;
        @(negedge clk);
        nchk++; if (a_waitrequest !== 1'b0 || mem_chipselect !== 1'b1) begin nerr++; $display("FAIL mid_grant: wait=%b cs=%b expected 0 1", a_waitrequest, mem_chipselect); end
        #1 reset = 1'b1;
        next_cycle();
        b_address = 10'h008; b_read = 1'b1;
        @(negedge clk);
        nchk++; if (a_readdatavalid !== 1'b0 || a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin nerr++; $display("FAIL mid_in_reset: aval=%b wa=%b wb=%b cs=%b expected 0 1 1 0", a_readdatavalid, a_waitrequest, b_waitrequest, mem_chipselect); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        nchk++; if (a_waitrequest !== 1'b0 || b_waitrequest !== 1'b1 || a_readdatavalid !== 1'b0) begin nerr++; $display("FAIL mid_first_tie: wa=%b wb=%b aval=%b expected 0 1 0", a_waitrequest, b_waitrequest, a_readdatavalid); end
        qa.push_back('{cyc + 1, shadow[10'h007]});
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            shadow[i] = (32'h0101_0101 * 32'(i)) ^ 32'hA5A5_0000;
            ram[i]    = shadow[i];
        end
        shadow[5] = 32'h1234_5678;
        ram[5]    = 32'h1234_5678;
        reset = 1'b1;
        a_address = '0; b_address = '0; b_byteenable = '0; b_writedata = '0;
        f_a_address = '0; f_b_address = '0; f_b_byteenable = '0; f_b_writedata = '0;
        f_mem_readdata = '0;
        idle_inputs();
        #1;
        test_reset();
        test_a_read();
        test_b_write_read();
        test_round_robin();
        test_fixed_prio();
        test_reset_midflight();
        repeat (2) next_cycle();
        @(negedge clk);
        nchk++;
        if (qa.size() != 0 || qb.size() != 0) begin
            nerr++;
            $display("FAIL drain: pending a=%0d b=%0d expected 0 0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
